// File: rtl/wishbone_bus_if_pkg.sv
// Shared state encodings and data defaults for the OpenMIPS-to-Wishbone bridge.
package wishbone_bus_if_pkg;

  localparam int REG_BUS_W = 32;
  localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    WB_IDLE       = 2'b00,
    WB_BUSY       = 2'b01,
    WB_WAIT_STALL = 2'b11
  } wb_state_e;

endpackage

// File: rtl/wishbone_bus_if.sv
// Bridges one OpenMIPS memory port (IF or MEM) to a single-beat Wishbone B3 classic master,
// stalling the pipeline until ACK, timeout or flush.
module wishbone_bus_if
  import wishbone_bus_if_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = REG_BUS_W,
  parameter int SEL_W   = DATA_W / 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  input  logic              cpu_ce_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic              cpu_we_i,
  input  logic [SEL_W-1:0]  cpu_sel_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              stallreq_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_we_o,
  output logic [SEL_W-1:0]  wb_sel_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  output logic              bus_err_o
);

  // Counter only has to reach TIMEOUT-1; with the timeout disabled it just saturates.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  wb_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rd_buf;
  logic              timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= WB_IDLE;
      cnt       <= '0;
      rd_buf    <= ZERO_WORD[DATA_W-1:0];
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= '0;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
      bus_err_o <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      unique case (state)
        WB_IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            wb_adr_o <= cpu_addr_i;
            wb_dat_o <= cpu_data_i;
            wb_we_o  <= cpu_we_i;
            wb_sel_o <= cpu_sel_i;
            wb_stb_o <= 1'b1;
            wb_cyc_o <= 1'b1;
            cnt      <= '0;
            state    <= WB_BUSY;
          end
        end
        WB_BUSY: begin
          if (flush_i) begin
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            state    <= WB_IDLE;
          end else if (wb_ack_i) begin
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            rd_buf   <= wb_dat_i;
            state    <= (stall_i != 6'd0) ? WB_WAIT_STALL : WB_IDLE;
          end else if (timeout_hit) begin
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            bus_err_o <= 1'b1;
            rd_buf    <= '0;
            state     <= WB_IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        WB_WAIT_STALL: begin
          // Data already captured; just wait for the rest of the pipeline to release.
          if (flush_i || stall_i == 6'd0) state <= WB_IDLE;
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    unique case (state)
      WB_IDLE: stallreq_o = cpu_ce_i && !flush_i;
      WB_BUSY: begin
        stallreq_o = !wb_ack_i && !flush_i && !timeout_hit;
        if (wb_ack_i) cpu_data_o = wb_dat_i;
      end
      WB_WAIT_STALL: cpu_data_o = rd_buf;
      default: ;
    endcase
  end

endmodule

// File: doc/wishbone_bus_if.md
Name: wishbone_bus_if

Overview:
Bridges one OpenMIPS memory port to a Wishbone B3 classic master interface. The port is either instruction fetch (rom_*) or data access (ram_*). The block sits directly downstream of the openmips core and is instantiated twice in the SoC top: once for IF, once for MEM.
- Turns the core's single-cycle ce/we/sel/addr/data request into a multi-cycle Wishbone cycle.
- Holds the pipeline via stallreq until the slave ACKs or a timeout fires.
- Returns read data to the core.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
SEL_W, 4, byte-select width (DATA_W/8)
TIMEOUT, 255, max cycles to wait for ACK in BUSY; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (reset when rst==0 at a rising clk edge)
stall_i  in  6  pipeline stall vector from ctrl
flush_i  in  1  pipeline flush; aborts any in-flight cycle
cpu_ce_i  in  1  core access request
cpu_addr_i  in  ADDR_W  core address
cpu_data_i  in  DATA_W  core write data
cpu_we_i  in  1  1=write
cpu_sel_i  in  SEL_W  core byte enables
cpu_data_o  out  DATA_W  read data to core
stallreq_o  out  1  stall request to ctrl
wb_dat_i  in  DATA_W  slave read data
wb_ack_i  in  1  slave acknowledge
wb_adr_o  out  ADDR_W  Wishbone address
wb_dat_o  out  DATA_W  Wishbone write data
wb_we_o  out  1  Wishbone write enable
wb_sel_o  out  SEL_W  Wishbone byte selects
wb_stb_o  out  1  Wishbone strobe
wb_cyc_o  out  1  Wishbone cycle
bus_err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset values: all wb_* outputs 0; state IDLE; read buffer 0; timeout counter 0; bus_err_o 0. The combinational outputs (stallreq_o, cpu_data_o) evaluate to 0 in IDLE with cpu_ce_i==0.
- States: IDLE, BUSY, WAIT_STALL; stored in a 2-bit register.
- IDLE:
  - If cpu_ce_i && !flush_i: register adr/dat/we/sel from the cpu_* inputs, set cyc=stb=1, clear the counter, go to BUSY.
  - stallreq_o = cpu_ce_i && !flush_i (combinational, same cycle).
  - cpu_data_o = 0.
- BUSY, checked in this priority order:
  1. flush_i: cyc=stb=we=0, go to IDLE, read data discarded. Flush wins over a same-cycle ack.
  2. wb_ack_i: cyc=stb=we=0, buffer <= wb_dat_i. Go to WAIT_STALL if stall_i != 0, else IDLE.
  3. TIMEOUT!=0 and counter==TIMEOUT-1: cyc=stb=0, bus_err_o=1 for one cycle, buffer <= 0, go to IDLE.
  4. Otherwise the counter increments. It saturates and never wraps when TIMEOUT==0.
- Outputs in BUSY:
  - stallreq_o = !wb_ack_i && !flush_i; it also drops in the timeout cycle.
  - cpu_data_o = wb_ack_i ? wb_dat_i : 0. This is a combinational bypass so the core samples the data in the ack cycle.
- WAIT_STALL:
  - Entered because the ack arrived while another stage was still stalling the pipeline.
  - cpu_data_o = buffer; stallreq_o = 0.
  - Returns to IDLE when stall_i == 0, or immediately on flush_i.
  - No new Wishbone cycle is issued from this state.
- Wishbone rules:
  - stb_o implies cyc_o.
  - adr/dat/we/sel are held constant for the whole cycle.
  - Single-beat only; no burst and no RTY/ERR input.
  - A back-to-back request needs at least one IDLE cycle between cycles.
- Latency: minimum 2 clocks from cpu_ce_i to data, with a zero-wait slave that ACKs in the first BUSY cycle.
- Reset mid-cycle drops cyc/stb in the same edge regardless of wb_ack_i.

Decomposition:
- Shared package/defines (defines.v): state encodings WB_IDLE=2'b00, WB_BUSY=2'b01, WB_WAIT_STALL=2'b11. Reuse the existing RegBus/ZeroWord macros for the data defaults.
- No sub-module; the timeout counter and FSM stay in one always block with a separate combinational output block.

Test Plan:
- Zero-wait read: cpu_ce=1, addr=0x0000_0040, we=0; slave ACKs on the first BUSY cycle with 0xDEADBEEF. Required: cyc/stb high exactly 1 cycle, cpu_data_o=0xDEADBEEF and stallreq_o=0 in the ack cycle, back in IDLE next cycle.
- 3-wait write: we=1, sel=4'b0011, data=0x1234_5678; ACK after 3 cycles. Required: wb_dat_o/sel/adr stable for 4 cycles, stallreq_o=1 for 4 cycles including the request cycle, wb_we_o=0 after ACK.
- Ack under foreign stall: ACK with wb_dat_i=0xA5A5_A5A5 while stall_i=6'b000111 for 2 more cycles. Required: state WAIT_STALL, cpu_data_o=0xA5A5_A5A5 held until stall_i==0, then IDLE, no new cycle issued.
- Flush in BUSY: flush_i=1 in the second BUSY cycle, same cycle as wb_ack_i. Required: cyc/stb=0 next edge, IDLE, buffer not updated, cpu_data_o=0.
- Timeout: TIMEOUT=4, slave never ACKs. Required: cyc high 4 cycles, bus_err_o pulses once, stallreq_o low from the timeout cycle, state IDLE.
- Reset mid-cycle: rst=0 in BUSY. Required: all wb_* outputs 0 at the next edge, state IDLE; after rst=1 a new request starts cleanly.
